// File: rtl/rect_fill_writer.sv
// Rectangle-fill engine: walks an X-by-Y box in a linear framebuffer and emits one
// address/colour write per accepted handshake, silently skipping addresses past the end.
module rect_fill_writer #(
   parameter int ROW_STRIDE = 640,
   parameter int FB_DEPTH   = 307200,
   parameter int DATA_W     = 3
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic [9:0]        X,
   input  logic [9:0]        Y,
   input  logic [18:0]       startaddr,
   input  logic [DATA_W-1:0] color,
   input  logic              wr_ready,
   output logic              wr_en,
   output logic [18:0]       wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} FillState;

   localparam logic [20:0] STRIDE21 = 21'(ROW_STRIDE);
   localparam logic [20:0] DEPTH21  = 21'(FB_DEPTH);

   FillState          state, nextState;
   logic [9:0]        boxW, boxH, nextBoxW, nextBoxH;
   logic [9:0]        col, row, nextCol, nextRow;
   logic [20:0]       rowBase, nextRowBase;
   logic [20:0]       curAddr, nextCur;
   logic [DATA_W-1:0] nextColor;
   logic              inRange, lastCol, lastRow;

   // Addresses are kept 21 bits wide so a box running off the bottom never aliases back to the top.
   assign curAddr = rowBase + {11'd0, col};
   assign inRange = curAddr < DEPTH21;
   assign lastCol = col == boxW - 10'd1;
   assign lastRow = row == boxH - 10'd1;

   always_comb begin
      nextState   = state;
      nextBoxW    = boxW;
      nextBoxH    = boxH;
      nextCol     = col;
      nextRow     = row;
      nextRowBase = rowBase;
      nextColor   = wr_data;
      case (state)
         IDLE: begin
            if (start) begin
               nextBoxW    = X;
               nextBoxH    = Y;
               nextColor   = color;
               nextCol     = '0;
               nextRow     = '0;
               nextRowBase = {2'b00, startaddr};
               nextState   = (X == 10'd0 || Y == 10'd0) ? DONE : FILL;
            end
         end
         FILL: begin
            // Clipped pixels never wait on the arbiter.
            if (!inRange || wr_ready) begin
               if (lastCol) begin
                  if (lastRow) begin
                     nextState = DONE;
                  end else begin
                     nextCol     = '0;
                     nextRow     = row + 10'd1;
                     nextRowBase = rowBase + STRIDE21;
                  end
               end else begin
                  nextCol = col + 10'd1;
               end
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
      nextCur = nextRowBase + {11'd0, nextCol};
   end

   // Outputs are registered from the next position, so they always describe the pixel held in col/row.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state   <= IDLE;
         boxW    <= '0;
         boxH    <= '0;
         col     <= '0;
         row     <= '0;
         rowBase <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= nextState;
         boxW    <= nextBoxW;
         boxH    <= nextBoxH;
         col     <= nextCol;
         row     <= nextRow;
         rowBase <= nextRowBase;
         wr_en   <= (nextState == FILL) && (nextCur < DEPTH21);
         wr_addr <= (nextState == FILL) ? nextCur[18:0] : 19'd0;
         wr_data <= nextColor;
         busy    <= nextState == FILL;
         done    <= nextState == DONE;
      end
   end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Scoreboard bench for rect_fill_writer: a box-walking reference model queues the expected
// writes and done pulses, and a monitor pops them on every handshake or done.
module tb_rect_fill_writer;

   localparam int DW = 3;

   logic          clock = 1'b0;
   logic          resetn, start, wr_ready;
   logic [9:0]    X, Y;
   logic [18:0]   startaddr;
   logic [DW-1:0] color;
   logic          wr_en, busy, done;
   logic [18:0]   wr_addr;
   logic [DW-1:0] wr_data;

   typedef struct packed {
      logic          isDone;
      logic [18:0]   addr;
      logic [DW-1:0] data;
   } ExpEntry;

   ExpEntry       sbq[$];
   int            checks = 0;
   int            errors = 0;
   int            hsCount = 0;
   int            hsBase = 0;
   int            readyMode = 0;
   logic          prevStall = 1'b0;
   logic [18:0]   prevAddr = '0;
   logic [DW-1:0] prevData = '0;

   rect_fill_writer #(.ROW_STRIDE(640), .FB_DEPTH(307200), .DATA_W(DW)) dut (
      .clock(clock), .resetn(resetn), .start(start), .X(X), .Y(Y),
      .startaddr(startaddr), .color(color), .wr_ready(wr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: every pixel of the box in raster order, dropping addresses past the framebuffer.
   task automatic pushModel(input int x, input int y, input int sa, input int c);
      ExpEntry e;
      for (int r = 0; r < y; r++) begin
         for (int cc = 0; cc < x; cc++) begin
            int a;
            a = sa + r * 640 + cc;
            if (a < 307200) begin
               e.isDone = 1'b0;
               e.addr   = 19'(a);
               e.data   = DW'(c);
               sbq.push_back(e);
            end
         end
      end
      e.isDone = 1'b1;
      e.addr   = '0;
      e.data   = '0;
      sbq.push_back(e);
   endtask

   task automatic applyStimulus(input int x, input int y, input int sa, input int c);
      X         = 10'(x);
      Y         = 10'(y);
      startaddr = 19'(sa);
      color     = DW'(c);
      start     = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      X         = 10'($urandom);
      Y         = 10'($urandom);
      startaddr = 19'($urandom);
      color     = DW'($urandom);
   endtask

   task automatic runFill(input int x, input int y, input int sa, input int c, input int expLat);
      int lat;
      int busyCnt;
      bit seen;
      hsBase = hsCount;
      pushModel(x, y, sa, c);
      applyStimulus(x, y, sa, c);
      lat = 0;
      busyCnt = 0;
      seen = 1'b0;
      for (int i = 0; i < x * y * 4 + 50; i++) begin
         lat++;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busyCnt++;
         @(negedge clock);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: no done after %0d cycles for %0dx%0d at %0d", lat, x, y, sa);
      end else begin
         checkOutput("busy_cycles", busyCnt, lat - 1);
         checkOutput("busy_wren_at_done", {busy, wr_en}, 0);
         if (expLat >= 0) checkOutput("done_latency", lat, expLat);
      end
      @(negedge clock);
   endtask

   // Monitor: pops the scoreboard on each accepted write or done pulse.
   always @(negedge clock) begin : monitor
      ExpEntry e;
      if (!resetn) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall)
            checkOutput("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, prevAddr, prevData});
         if (wr_en && wr_ready) begin
            hsCount++;
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_write: addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
               e = sbq.pop_front();
               if (e.isDone || e.addr != wr_addr || e.data != wr_data) begin
                  errors++;
                  $display("[TB] FAIL write: got addr %0d data %0d, expected %s addr %0d data %0d",
                           wr_addr, wr_data, e.isDone ? "done" : "write", e.addr, e.data);
               end
            end
         end
         if (done) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_done: got done, expected nothing pending");
            end else begin
               e = sbq.pop_front();
               if (!e.isDone) begin
                  errors++;
                  $display("[TB] FAIL done_order: got done, expected write addr %0d", e.addr);
               end
            end
         end
         prevStall = wr_en && !wr_ready;
         prevAddr  = wr_addr;
         prevData  = wr_data;
      end
   end

   // Arbiter model: always ready, random, or stalling the 2nd and 4th write for 3 cycles each.
   initial begin : readyDriver
      int idx;
      int stallLeft;
      int lastStalled;
      stallLeft = 0;
      lastStalled = -1;
      wr_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (readyMode)
            1: wr_ready = ($urandom_range(0, 3) != 0);
            2: begin
               idx = hsCount - hsBase;
               if (idx == 0) lastStalled = -1;
               if (stallLeft > 0) begin
                  wr_ready = 1'b0;
                  stallLeft--;
               end else if (wr_en && (idx == 1 || idx == 3) && idx != lastStalled) begin
                  wr_ready = 1'b0;
                  stallLeft = 2;
                  lastStalled = idx;
               end else begin
                  wr_ready = 1'b1;
               end
            end
            default: wr_ready = 1'b1;
         endcase
      end
   end

   task automatic heldStartTest();
      int idx;
      int dones;
      int firstDone;
      pushModel(5, 1, 2000, 2);
      pushModel(5, 1, 2000, 2);
      X = 10'd5;
      Y = 10'd1;
      startaddr = 19'd2000;
      color = 3'd2;
      start = 1'b1;
      idx = 0;
      dones = 0;
      firstDone = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         idx++;
         if (done) begin
            dones++;
            if (dones == 1) firstDone = idx;
            else break;
         end
         if (idx == 7) checkOutput("held_idle_gap", {busy, wr_en}, 0);
         if (idx == 8) start = 1'b0;
      end
      start = 1'b0;
      checkOutput("held_first_done", firstDone, 6);
      checkOutput("held_done_count", dones, 2);
      @(negedge clock);
   endtask

   task automatic resetMidFillTest();
      bit reached;
      hsBase = hsCount;
      pushModel(10, 10, 5000, 6);
      applyStimulus(10, 10, 5000, 6);
      reached = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         #1;
         if (hsCount - hsBase == 37) begin
            reached = 1'b1;
            break;
         end
      end
      if (!reached) begin
         checks++;
         errors++;
         $display("[TB] FAIL reset_wait: got %0d writes, expected 37", hsCount - hsBase);
      end
      resetn = 1'b0;
      sbq.delete();
      @(negedge clock);
      #1;
      checkOutput("post_reset_outputs", {wr_en, wr_addr, wr_data, busy, done}, 0);
      resetn = 1'b1;
      repeat (6) @(negedge clock);
      checkOutput("writes_before_reset", hsCount - hsBase, 37);
      runFill(1, 1, 0, 3, 2);
   endtask

   initial begin
      resetn = 1'b0;
      start = 1'b0;
      X = '0;
      Y = '0;
      startaddr = '0;
      color = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset_outputs", {wr_en, wr_addr, wr_data, busy, done}, 0);
      resetn = 1'b1;
      @(negedge clock);

      readyMode = 0;
      runFill(3, 2, 1000, 5, 7);
      readyMode = 2;
      runFill(3, 2, 1000, 5, 13);
      checkOutput("stalled_handshakes", hsCount - hsBase, 6);
      readyMode = 0;
      runFill(0, 7, 1234, 4, 1);
      runFill(4, 0, 1234, 4, 1);
      runFill(4, 2, 307198, 7, 9);
      checkOutput("clipped_writes", hsCount - hsBase, 2);
      runFill(1023, 2, 306500, 1, 2047);
      heldStartTest();
      resetMidFillTest();

      readyMode = 1;
      for (int n = 0; n < 12; n++) begin
         int x, y, sa, sel;
         x = $urandom_range(0, 12);
         y = $urandom_range(0, 6);
         sel = $urandom_range(0, 3);
         if (sel == 0) sa = 307200 - $urandom_range(0, 1500);
         else if (sel == 1) sa = $urandom_range(307200, 524287);
         else sa = $urandom_range(0, 307199);
         runFill(x, y, sa, $urandom_range(0, 7), -1);
      end
      readyMode = 0;
      repeat (3) @(negedge clock);
      checkOutput("scoreboard_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
